seviyeli_hafiza_istemci: RTL and testbench
==========================================

Name: seviyeli_hafiza_istemci

Overview:
- Initiator for the two-level paged memory (64 x 8 data, level-1/level-2 tables, 2-bit fault counter).
- Accepts host read/write requests on a valid/ready channel and drives the memory's adres/yazoku/deger pins with the exact per-cycle sequence the memory needs. Write is one cycle. Read is a 3-step walk: L1, L2, then data.
- Captures read data and the per-transaction fault delta, and returns both on a valid/ready response channel.

Parameters:
- ADDR_W, 6, memory address width
- DATA_W, 8, data width
- FCNT_W, 16, cumulative fault statistic width (used only with the optional feature)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  host request valid
- req_ready  out  1  high only in IDLE
- req_write  in  1  1 = write, 0 = read
- req_adres  in  ADDR_W  request address
- req_deger  in  DATA_W  write data
- rsp_valid  out  1  response valid
- rsp_ready  in  1  host accepts response
- rsp_data  out  DATA_W  read data; 0 for writes
- rsp_write  out  1  echo of req_write
- rsp_faults  out  2  faults incurred by this transaction
- mem_adres  out  ADDR_W  to memory adres
- mem_yazoku  out  1  to memory yazoku
- mem_deger  out  DATA_W  to memory deger
- mem_sonuc  in  DATA_W  from memory sonuc
- mem_hata  in  2  from memory hata_sayisi
- fault_total  out  FCNT_W  cumulative faults; 0 when the feature is compiled out

Behaviour:
- States: IDLE, WRITE, WALK_L1, WALK_L2, DATA, RESP. Reset to IDLE.
- Reset values: rsp_valid=0, rsp_data=0, rsp_write=0, rsp_faults=0, fault_total=0.
- Shadow register (sh_adres, sh_deger): reset value 0/0, which matches the memory's power-up contents.
- IDLE:
  - The memory walks a level on every yazoku=0 cycle, so in IDLE the block drives mem_yazoku=1, mem_adres=sh_adres, mem_deger=sh_deger. This is a harmless rewrite.
  - req_ready=1.
  - On req_valid: latch the request, latch base=mem_hata, go to WRITE or WALK_L1.
- WRITE:
  - Drive yazoku=1, adres/deger = request.
  - Update the shadow with the request.
  - Go to RESP.
- WALK_L1 / WALK_L2 / DATA:
  - Drive yazoku=0, adres=request address, mem_deger=sh_deger.
  - Advance one state per cycle, with no stalls.
  - In DATA, register mem_sonuc into rsp_data at the clock edge.
- RESP:
  - mem pins return to IDLE drive.
  - rsp_valid=1. rsp_faults=(mem_hata - base) mod 4, computed in the first RESP cycle and held.
  - All rsp_* outputs stay stable until rsp_ready. On rsp_valid&&rsp_ready go to IDLE.
  - A new request is accepted no earlier than the cycle after the handshake.
- Latency from the accept edge to rsp_valid: write 2 cycles, read 4 cycles. Reads never issue back-to-back walk steps across transactions.
- Fault counter wrap: mem_hata is 2 bits and can wrap. The subtraction is modulo 4; at most 2 faults per read, 0 per write.
- rsp_ready held high: response is consumed in the first RESP cycle. Throughput is 1 read per 5 cycles and 1 write per 3 cycles.
- req_valid is ignored outside IDLE. The request fields are sampled only at accept.
- rst mid-transaction: the transaction is abandoned with no response and the state goes to IDLE. The shadow is reset, but the memory's walk level is not. The memory must receive the same rst, or level recovery is the system's responsibility.

Optional Feature:
- Macro SEVIYELI_HAFIZA_FAULT_STATS_EN.
- Defined: fault_total accumulates rsp_faults at each response handshake. It saturates at all-ones and is cleared by rst.
- Undefined: fault_total is tied to 0 and no accumulator is synthesised.

Decomposition:
- Shared package seviyeli_hafiza_pkg holds:
  - the state enum
  - ADDR_W/DATA_W defaults
  - the walk step count (3)
  - the page size constant (8)
  - the IDLE shadow reset values
- No sub-module is needed. The FSM, shadow register and fault-delta logic stay in one module.

Test Plan:
- Write adres=5, deger=0xA7, then read adres=5 -> write rsp_valid 2 cycles after accept with rsp_faults=0. Read rsp_data=0xA7 4 cycles after accept.
- Read adres=40 from reset -> rsp_faults=2 (L1 page change plus L2 miss).
- Read adres=40 again immediately -> rsp_faults=0 and data unchanged.
- Hold rsp_ready=0 for 7 cycles during a read -> rsp_* stable and req_ready=0 throughout; accept occurs the cycle after the handshake.
- Drive enough reads to wrap mem_hata 3->1 -> rsp_faults=2, not 2'b10 misinterpreted. With the macro defined, fault_total sums correctly; without it, fault_total stays 0.
- Assert rst during WALK_L2 -> no rsp_valid, state IDLE, mem_yazoku=1 with adres 0/deger 0 the next cycle.

Source files
------------

// File: rtl/seviyeli_hafiza_pkg.sv
// Shared definitions for the two-level paged memory initiator.
// Holds the FSM state encoding, default widths, walk geometry, the
// shadow-register reset values and the modulo-4 fault delta helper.
package seviyeli_hafiza_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 8;
    localparam int FCNT_W_DEF = 16;

    // A read walks L1, L2, then the data array: one memory cycle each.
    localparam int WALK_STEPS = 3;
    // Entries per page; the page number is the address above this boundary.
    localparam int PAGE_SIZE  = 8;

    // Shadow reset values equal the memory's power-up contents, so the
    // IDLE rewrite after reset cannot corrupt anything.
    localparam logic [ADDR_W_DEF-1:0] SH_ADRES_RST = '0;
    localparam logic [DATA_W_DEF-1:0] SH_DEGER_RST = '0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_WALK_L1 = 3'd2,
        ST_WALK_L2 = 3'd3,
        ST_DATA    = 3'd4,
        ST_RESP    = 3'd5
    } state_e;

    // The memory's fault counter is 2 bits and wraps; the 2-bit subtraction
    // gives the correct per-transaction delta as long as it is below 4.
    function automatic logic [1:0] fault_delta(input logic [1:0] now,
                                               input logic [1:0] base);
        return now - base;
    endfunction

endpackage

// File: rtl/seviyeli_hafiza_istemci_if.sv
// Host request/response channel plus the memory pin bundle.
// slave: the initiator block; master: the host/memory side.
interface seviyeli_hafiza_istemci_if
    import seviyeli_hafiza_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_adres;
    logic [DATA_W-1:0] req_deger;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_write;
    logic [1:0]        rsp_faults;

    logic [ADDR_W-1:0] mem_adres;
    logic              mem_yazoku;
    logic [DATA_W-1:0] mem_deger;
    logic [DATA_W-1:0] mem_sonuc;
    logic [1:0]        mem_hata;

    modport slave (
        input  req_valid, req_write, req_adres, req_deger, rsp_ready,
               mem_sonuc, mem_hata,
        output req_ready, rsp_valid, rsp_data, rsp_write, rsp_faults,
               mem_adres, mem_yazoku, mem_deger
    );

    modport master (
        output req_valid, req_write, req_adres, req_deger, rsp_ready,
               mem_sonuc, mem_hata,
        input  req_ready, rsp_valid, rsp_data, rsp_write, rsp_faults,
               mem_adres, mem_yazoku, mem_deger
    );

endinterface

// File: rtl/seviyeli_hafiza_istemci.sv
// Initiator for the two-level paged memory. Turns host read/write requests
// into the memory's per-cycle pin sequence (write: one cycle; read: L1, L2,
// data walk) and returns read data plus the fault delta of the transaction.
// Optional macro SEVIYELI_HAFIZA_FAULT_STATS_EN enables a saturating
// cumulative fault counter on fault_total; otherwise fault_total is 0.
module seviyeli_hafiza_istemci
    import seviyeli_hafiza_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int FCNT_W = FCNT_W_DEF
)(
    input  logic                      clk,
    input  logic                      rst,
    seviyeli_hafiza_istemci_if.slave  bus,
    output logic [FCNT_W-1:0]         fault_total
);

    state_e              state_q,      state_d;
    logic [ADDR_W-1:0]   adres_q,      adres_d;
    logic [DATA_W-1:0]   deger_q,      deger_d;
    logic                write_q,      write_d;
    logic [1:0]          base_q,       base_d;
    logic [ADDR_W-1:0]   sh_adres_q,   sh_adres_d;
    logic [DATA_W-1:0]   sh_deger_q,   sh_deger_d;
    logic [DATA_W-1:0]   rsp_data_q,   rsp_data_d;
    logic [1:0]          rsp_faults_q, rsp_faults_d;

    logic rsp_fire;
    assign rsp_fire = (state_q == ST_RESP) && bus.rsp_ready;

    // Next-state, request/shadow capture and memory pin drive.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        adres_d      = adres_q;
        deger_d      = deger_q;
        write_d      = write_q;
        base_d       = base_q;
        sh_adres_d   = sh_adres_q;
        sh_deger_d   = sh_deger_q;
        rsp_data_d   = rsp_data_q;
        rsp_faults_d = rsp_faults_q;

        // Idle drive: a rewrite of the last written location, which never
        // advances the memory's walk level.
        bus.req_ready  = 1'b0;
        bus.mem_yazoku = 1'b1;
        bus.mem_adres  = sh_adres_q;
        bus.mem_deger  = sh_deger_q;

        unique case (state_q)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    adres_d = bus.req_adres;
                    deger_d = bus.req_deger;
                    write_d = bus.req_write;
                    base_d  = bus.mem_hata;
                    state_d = bus.req_write ? ST_WRITE : ST_WALK_L1;
                end
            end
            ST_WRITE: begin
                bus.mem_adres = adres_q;
                bus.mem_deger = deger_q;
                sh_adres_d    = adres_q;
                sh_deger_d    = deger_q;
                rsp_data_d    = '0;
                rsp_faults_d  = 2'd0;
                state_d       = ST_RESP;
            end
            ST_WALK_L1, ST_WALK_L2, ST_DATA: begin
                bus.mem_yazoku = 1'b0;
                bus.mem_adres  = adres_q;
                if (state_q == ST_WALK_L1) begin
                    state_d = ST_WALK_L2;
                end else if (state_q == ST_WALK_L2) begin
                    state_d = ST_DATA;
                end else begin
                    // Both walk faults are already counted by the memory, so
                    // the delta is final here and visible in the first RESP cycle.
                    rsp_data_d   = bus.mem_sonuc;
                    rsp_faults_d = fault_delta(bus.mem_hata, base_q);
                    state_d      = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, request, shadow and response registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling the
        // pre-edge value, independent of statement order.
        if (rst) begin
            state_q      <= ST_IDLE;
            adres_q      <= '0;
            deger_q      <= '0;
            write_q      <= 1'b0;
            base_q       <= 2'd0;
            // NOTE: the shadow must be reset, not just initialised by the
            // first write, because IDLE drives it onto the memory pins.
            sh_adres_q   <= ADDR_W'(SH_ADRES_RST);
            sh_deger_q   <= DATA_W'(SH_DEGER_RST);
            rsp_data_q   <= '0;
            rsp_faults_q <= 2'd0;
        end else begin
            state_q      <= state_d;
            adres_q      <= adres_d;
            deger_q      <= deger_d;
            write_q      <= write_d;
            base_q       <= base_d;
            sh_adres_q   <= sh_adres_d;
            sh_deger_q   <= sh_deger_d;
            rsp_data_q   <= rsp_data_d;
            rsp_faults_q <= rsp_faults_d;
        end
    end

    assign bus.rsp_valid  = (state_q == ST_RESP);
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_write  = write_q;
    assign bus.rsp_faults = rsp_faults_q;

`ifdef SEVIYELI_HAFIZA_FAULT_STATS_EN
    logic [FCNT_W-1:0] fault_total_q, fault_total_d;
    logic [FCNT_W:0]   fault_sum;

    // Saturating accumulation of per-transaction faults at each handshake.
    always_comb begin
        fault_sum     = {1'b0, fault_total_q} + {{(FCNT_W-1){1'b0}}, rsp_faults_q};
        fault_total_d = fault_total_q;
        if (rsp_fire) begin
            fault_total_d = fault_sum[FCNT_W] ? {FCNT_W{1'b1}} : fault_sum[FCNT_W-1:0];
        end
    end

    // Fault statistic register, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_total_q <= '0;
        end else begin
            fault_total_q <= fault_total_d;
        end
    end

    assign fault_total = fault_total_q;
`else
    logic unused_fire;
    assign unused_fire = rsp_fire;
    assign fault_total = '0;
`endif

endmodule

// File: tb/tb_seviyeli_hafiza_istemci.sv
// Directed self-checking bench for seviyeli_hafiza_istemci with a
// behavioural model of the two-level paged memory (page = 8 entries,
// L1 page register, L2 per-page valid bits, 2-bit wrapping fault counter).
module tb_seviyeli_hafiza_istemci;
    import seviyeli_hafiza_pkg::*;

`ifdef SEVIYELI_HAFIZA_FAULT_STATS_EN
    localparam logic [15:0] EXP_TOTAL = 16'd5;
`else
    localparam logic [15:0] EXP_TOTAL = 16'd0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] fault_total;
    int          checks   = 0;
    int          failures = 0;

    seviyeli_hafiza_istemci_if #(.ADDR_W(6), .DATA_W(8)) bus ();

    seviyeli_hafiza_istemci #(.ADDR_W(6), .DATA_W(8), .FCNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .fault_total (fault_total)
    );

    always #5 clk = ~clk;

    // Memory model: write on yazoku=1, walk one level per yazoku=0 cycle.
    logic [7:0] mem [64];
    logic [2:0] l1_page;
    logic [7:0] l2_valid;
    logic [1:0] level;
    logic [1:0] hata;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
            l1_page  <= 3'd0;
            l2_valid <= 8'b0000_0001;
            level    <= 2'd0;
            hata     <= 2'd0;
        end else if (bus.mem_yazoku) begin
            mem[bus.mem_adres] <= bus.mem_deger;
        end else begin
            case (level)
                2'd0: begin
                    if (bus.mem_adres[5:3] != l1_page) begin
                        l1_page <= bus.mem_adres[5:3];
                        hata    <= hata + 2'd1;
                    end
                    level <= 2'd1;
                end
                2'd1: begin
                    if (!l2_valid[bus.mem_adres[5:3]]) begin
                        l2_valid[bus.mem_adres[5:3]] <= 1'b1;
                        hata <= hata + 2'd1;
                    end
                    level <= 2'd2;
                end
                default: level <= 2'd0;
            endcase
        end
    end

    assign bus.mem_sonuc = mem[bus.mem_adres];
    assign bus.mem_hata  = hata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One transaction with rsp_ready high; starts and ends on a negedge in IDLE.
    task automatic do_req(input string tag, input logic wr, input logic [5:0] a,
                          input logic [7:0] d, input int exp_lat,
                          input logic [7:0] exp_data, input logic [1:0] exp_f);
        int n;
        check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_adres = a;
        bus.req_deger = d;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 1;
        while (!bus.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check({tag, "_data"},    32'(bus.rsp_data),   32'(exp_data));
        check({tag, "_faults"},  32'(bus.rsp_faults), 32'(exp_f));
        check({tag, "_write"},   32'(bus.rsp_write),  32'(wr));
        @(negedge clk);
        check({tag, "_idle_valid"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_adres = '0;
        bus.req_deger = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_rsp_valid",  32'(bus.rsp_valid),  32'd0);
        check("rst_rsp_data",   32'(bus.rsp_data),   32'd0);
        check("rst_rsp_write",  32'(bus.rsp_write),  32'd0);
        check("rst_rsp_faults", 32'(bus.rsp_faults), 32'd0);
        check("rst_fault_total", 32'(fault_total),   32'd0);
        check("rst_yazoku",     32'(bus.mem_yazoku), 32'd1);
        check("rst_adres",      32'(bus.mem_adres),  32'd0);
        check("rst_deger",      32'(bus.mem_deger),  32'd0);

        // Write then read back; same page, no faults
        do_req("wr5",  1'b1, 6'd5,  8'hA7, 2, 8'h00, 2'd0);
        check("wr5_shadow_adres", 32'(bus.mem_adres), 32'd5);
        check("wr5_shadow_deger", 32'(bus.mem_deger), 32'hA7);
        do_req("rd5",  1'b0, 6'd5,  8'h00, 4, 8'hA7, 2'd0);
        // Page change plus L2 miss, then a repeat with no faults
        do_req("rd40a", 1'b0, 6'd40, 8'h00, 4, 8'h00, 2'd2);
        do_req("rd40b", 1'b0, 6'd40, 8'h00, 4, 8'h00, 2'd0);
        do_req("wr41", 1'b1, 6'd41, 8'h3C, 2, 8'h00, 2'd0);

        // Response back-pressure for 7 cycles; a pending request must wait
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_adres = 6'd41;
        @(posedge clk);
        @(negedge clk);
        bus.req_write = 1'b1;
        bus.req_adres = 6'd0;
        bus.req_deger = 8'h11;
        n = 1;
        while (!bus.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("stall_latency", 32'(n), 32'd4);
        for (int i = 0; i < 7; i++) begin
            check("stall_valid",     32'(bus.rsp_valid),  32'd1);
            check("stall_data",      32'(bus.rsp_data),   32'h3C);
            check("stall_faults",    32'(bus.rsp_faults), 32'd0);
            check("stall_write",     32'(bus.rsp_write),  32'd0);
            check("stall_req_ready", 32'(bus.req_ready),  32'd0);
            check("stall_yazoku",    32'(bus.mem_yazoku), 32'd1);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        check("stall_last_valid", 32'(bus.rsp_valid), 32'd1);
        @(negedge clk);
        check("post_hs_valid",     32'(bus.rsp_valid), 32'd0);
        check("post_hs_req_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 1;
        while (!bus.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("queued_wr_latency", 32'(n), 32'd2);
        check("queued_wr_write",   32'(bus.rsp_write), 32'd1);
        check("queued_wr_data",    32'(bus.rsp_data),  32'd0);
        @(negedge clk);

        // Fault counter: 2 -> 3, then 3 -> 1 (wrap), delta 2
        do_req("rd5b", 1'b0, 6'd5,  8'h00, 4, 8'hA7, 2'd1);
        do_req("rd48", 1'b0, 6'd48, 8'h00, 4, 8'h00, 2'd2);
        check("fault_total", 32'(fault_total), 32'(EXP_TOTAL));

        // Reset during WALK_L2 abandons the read
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_adres = 6'd45;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("mid_state_l2", 32'(dut.state_q), 32'(ST_WALK_L2));
        check("mid_yazoku_l2", 32'(bus.mem_yazoku), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rsp_valid",   32'(bus.rsp_valid),  32'd0);
        check("mid_state",       32'(dut.state_q),    32'(ST_IDLE));
        check("mid_yazoku",      32'(bus.mem_yazoku), 32'd1);
        check("mid_adres",       32'(bus.mem_adres),  32'd0);
        check("mid_deger",       32'(bus.mem_deger),  32'd0);
        check("mid_fault_total", 32'(fault_total),    32'd0);
        @(negedge clk);
        check("mid_rsp_valid2",  32'(bus.rsp_valid),  32'd0);
        do_req("rd5_after_rst", 1'b0, 6'd5, 8'h00, 4, 8'h00, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
